// File: rtl/io_cond_pkg.sv
// Shared types and bus geometry for the IO input conditioner.
package io_cond_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam int unsigned NUM_SW   = 18;
    localparam int unsigned NUM_KEY  = 4;
    localparam int unsigned IO_WIDTH = 22;
    localparam int unsigned KEY_BASE = 18;

endpackage

// File: rtl/key_debouncer.sv
// One push key: synchroniser, polarity normalisation and a debounce FSM with
// registered level, press and release outputs.
module key_debouncer
    import io_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic released
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt;
    logic                   p;
    deb_state_t             state;

    // Preload the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{KEY_ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign p = sync_q[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            press    <= 1'b0;
            released <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (p) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state <= IDLE;
                    end else if (cnt == CntLast) begin
                        state <= PRESSED;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!p) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (p) begin
                        state <= PRESSED;
                    end else if (cnt == CntLast) begin
                        state    <= IDLE;
                        level    <= 1'b0;
                        released <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Builds the 22-bit IO_input bus: synchronised switches plus debounced keys,
// with per-key press/release pulses and sticky press events.
module io_input_conditioner
    import io_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                physical_clock,
    input  logic                reset,
    input  logic [NUM_SW-1:0]   raw_sw,
    input  logic [NUM_KEY-1:0]  raw_key,
    input  logic [NUM_KEY-1:0]  event_clr,
    output logic [IO_WIDTH-1:0] IO_input,
    output logic [NUM_KEY-1:0]  key_press,
    output logic [NUM_KEY-1:0]  key_release,
    output logic [NUM_KEY-1:0]  key_event
);
    logic [SYNC_STAGES-1:0][NUM_SW-1:0] sw_sync;
    logic [NUM_KEY-1:0]                 key_level;

    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            sw_sync <= '0;
        end else begin
            sw_sync <= {sw_sync[SYNC_STAGES-2:0], raw_sw};
        end
    end

    for (genvar k = 0; k < NUM_KEY; k++) begin : gen_key
        key_debouncer #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
        ) u_deb (
            .clk      (physical_clock),
            .rst      (reset),
            .raw      (raw_key[k]),
            .level    (key_level[k]),
            .press    (key_press[k]),
            .released (key_release[k])
        );
    end

    // A press arriving with a clear in the same cycle must not be lost.
    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            key_event <= '0;
        end else begin
            key_event <= (key_event & ~event_clr) | key_press;
        end
    end

    assign IO_input[NUM_SW-1:0]          = sw_sync[SYNC_STAGES-1];
    assign IO_input[KEY_BASE +: NUM_KEY] = key_level;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomised bench for io_input_conditioner with a stable-run debounce model
// and directed literal checks on the key scenarios.
module tb_io_input_conditioner;
    localparam int S   = 2;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] raw_sw;
    logic [3:0]  raw_key;
    logic [3:0]  event_clr;
    logic [21:0] IO_input;
    logic [3:0]  key_press;
    logic [3:0]  key_release;
    logic [3:0]  key_event;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pipelines of sampled raw values, per-key stable-run length.
    logic [17:0] m_swp [S];
    logic [3:0]  m_kp  [S];
    logic [17:0] m_sw_out;
    logic [3:0]  m_level, m_press, m_rel, m_ev;
    int          m_run [4];

    always #5 clk = ~clk;

    io_input_conditioner #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (DEB),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .physical_clock (clk),
        .reset          (reset),
        .raw_sw         (raw_sw),
        .raw_key        (raw_key),
        .event_clr      (event_clr),
        .IO_input       (IO_input),
        .key_press      (key_press),
        .key_release    (key_release),
        .key_event      (key_event)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            m_swp[i] = '0;
            m_kp[i]  = 4'hF;
        end
        for (int k = 0; k < 4; k++) m_run[k] = 0;
        m_sw_out = '0;
        m_level  = '0;
        m_press  = '0;
        m_rel    = '0;
        m_ev     = '0;
    endtask

    // A key level flips once p has disagreed with it for DEB+1 consecutive edges.
    task automatic model_edge();
        logic p;
        m_ev    = (m_ev & ~event_clr) | m_press;
        m_press = '0;
        m_rel   = '0;
        for (int k = 0; k < 4; k++) begin
            p = ~m_kp[S-1][k];
            if (p != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB + 1) begin
                    m_level[k] = p;
                    if (p) m_press[k] = 1'b1;
                    else   m_rel[k]   = 1'b1;
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        for (int i = S - 1; i > 0; i--) begin
            m_swp[i] = m_swp[i-1];
            m_kp[i]  = m_kp[i-1];
        end
        m_swp[0] = raw_sw;
        m_kp[0]  = raw_key;
        m_sw_out = m_swp[S-1];
    endtask

    // One clock: advance the model on the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
        check("io_input",    32'(IO_input),    32'({m_level, m_sw_out}));
        check("key_press",   32'(key_press),   32'(m_press));
        check("key_release", 32'(key_release), 32'(m_rel));
        check("key_event",   32'(key_event),   32'(m_ev));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        model_reset();
        steps(n);
        reset = 1'b0;
    endtask

    int hold [4];

    initial begin
        reset     = 1'b1;
        raw_sw    = '0;
        raw_key   = 4'hF;
        event_clr = '0;
        model_reset();
        @(negedge clk);
        steps(3);
        reset = 1'b0;

        // Reset behaviour: quiet for 20 cycles.
        steps(20);
        check("rst_io", 32'(IO_input), 32'h0);
        check("rst_ev", 32'(key_event), 32'h0);

        // Switch synchroniser: two-edge delay.
        raw_sw = 18'h2A5A5;
        step();
        check("sw_edge1", 32'(IO_input[17:0]), 32'h0);
        step();
        check("sw_edge2", 32'(IO_input[17:0]), 32'h2A5A5);
        raw_sw = '0;
        steps(3);

        // Clean press on key 0.
        raw_key[0] = 1'b0;
        steps(6);
        check("press0_early", 32'(key_press), 32'h0);
        step();
        check("press0_pulse", 32'(key_press), 32'h1);
        check("press0_level", 32'(IO_input[18]), 32'h1);
        step();
        check("press0_once", 32'(key_press), 32'h0);
        check("press0_event", 32'(key_event), 32'h1);
        raw_key[0] = 1'b1;
        steps(6);
        check("rel0_early", 32'(key_release), 32'h0);
        step();
        check("rel0_pulse", 32'(key_release), 32'h1);
        check("rel0_level", 32'(IO_input[18]), 32'h0);
        steps(2);

        // Bounce rejection on key 2.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) raw_key[2] = ~raw_key[2];
            step();
        end
        raw_key[2] = 1'b1;
        steps(8);
        check("bounce_level", 32'(IO_input[20]), 32'h0);
        check("bounce_event", 32'(key_event[2]), 32'h0);

        // Same-cycle set and clear on key 1: set wins.
        raw_key[1] = 1'b0;
        steps(7);
        check("race_press", 32'(key_press[1]), 32'h1);
        event_clr[1] = 1'b1;
        step();
        check("race_set_wins", 32'(key_event[1]), 32'h1);
        step();
        check("race_cleared", 32'(key_event[1]), 32'h0);
        event_clr = '0;
        raw_key[1] = 1'b1;
        steps(10);

        // Reset in the middle of a key 3 debounce.
        raw_key[3] = 1'b0;
        steps(5);
        check("mid_no_press", 32'(key_press), 32'h0);
        pulse_reset(2);
        steps(6);
        check("mid_after_early", 32'(key_press), 32'h0);
        step();
        check("mid_after_pulse", 32'(key_press), 32'h8);
        raw_key[3] = 1'b1;
        steps(10);

        // Randomised phase: held key segments, random switches and clears.
        for (int k = 0; k < 4; k++) hold[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            raw_sw = 18'($urandom);
            for (int k = 0; k < 4; k++) begin
                if (hold[k] == 0) begin
                    raw_key[k] = 1'($urandom);
                    hold[k] = int'($urandom_range(1, 12));
                end
                hold[k]--;
            end
            event_clr = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            if (c == 1500) pulse_reset(2);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
